// File: rtl/accum_arbiter.sv
// accum_arbiter: round-robin arbiter sharing one AW-bit add/accumulate
// datapath among NREQ requesters, each with a private accumulator context
// and sticky carry flag. Responses come back one cycle after acceptance.
module accum_arbiter #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = 8,
  parameter  int unsigned AW   = 16,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [DW*NREQ-1:0]  req_data,
  output logic                rsp_valid,
  output logic [IW-1:0]       rsp_id,
  output logic [AW-1:0]       rsp_data,
  output logic                rsp_ovf
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  // Index arithmetic modulo NREQ (NREQ need not be a power of two).
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base,
                                             input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  logic [IW-1:0]  r_ptr;
  logic [AW-1:0]  r_acc [NREQ];
  logic [NREQ-1:0] r_ovf;
  logic           r_rsp_valid;
  logic [IW-1:0]  r_rsp_id;
  logic [AW-1:0]  r_rsp_data;
  logic           r_rsp_ovf;

  logic [1:0]     w_op_arr   [NREQ];
  logic [DW-1:0]  w_data_arr [NREQ];
  logic           w_found;
  logic           w_accept;
  logic [IW-1:0]  w_gnt_idx;
  logic [AW:0]    w_sum;
  logic [AW-1:0]  w_new_acc;
  logic           w_new_ovf;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_arr[gi]   = req_op[2*gi +: 2];
    assign w_data_arr[gi] = req_data[DW*gi +: DW];
  end

  // Round-robin search: first valid index starting at r_ptr.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrap_idx(r_ptr, k)]) begin
        w_found   = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
    w_accept = w_found && rst_n;
  end

  // One-hot grant, forced to zero while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  // Shared adder and operation decode for the granted context.
  always_comb begin
    w_sum     = {1'b0, r_acc[w_gnt_idx]} + {{(AW+1-DW){1'b0}}, w_data_arr[w_gnt_idx]};
    w_new_acc = r_acc[w_gnt_idx];
    w_new_ovf = r_ovf[w_gnt_idx];
    case (w_op_arr[w_gnt_idx])
      OP_ADD: begin
        w_new_acc = w_sum[AW-1:0];
        w_new_ovf = r_ovf[w_gnt_idx] | w_sum[AW];
      end
      OP_CLR: begin
        w_new_acc = '0;
        w_new_ovf = 1'b0;
      end
      OP_LOAD: begin
        w_new_acc = {{(AW-DW){1'b0}}, w_data_arr[w_gnt_idx]};
        w_new_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  // Context update, pointer advance and registered response on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) r_acc[i] <= '0;
      r_ovf       <= '0;
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_acc[w_gnt_idx] <= w_new_acc;
        r_ovf[w_gnt_idx] <= w_new_ovf;
        r_ptr            <= wrap_idx(w_gnt_idx, 1);
        r_rsp_id         <= w_gnt_idx;
        r_rsp_data       <= w_new_acc;
        r_rsp_ovf        <= w_new_ovf;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_accum_arbiter.sv
// Scoreboard bench for accum_arbiter: stimulus checks grants and queues the
// expected response; a negedge monitor pops and compares each response.
module tb_accum_arbiter;

  localparam logic [1:0] ADD = 2'b00, CLR = 2'b01, LOAD = 2'b10, READ = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ovf;

  typedef struct {
    int          id;
    logic [15:0] d;
    logic        o;
  } rsp_t;

  rsp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  accum_arbiter #(.NREQ(4), .DW(8), .AW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every response must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=%h ovf=%b, expected no response",
                 rsp_id, rsp_data, rsp_ovf);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (rsp_id !== 2'(e.id) || rsp_data !== e.d || rsp_ovf !== e.o) begin
          errors++;
          $display("FAIL rsp: got id=%0d data=%h ovf=%b, expected id=%0d data=%h ovf=%b",
                   rsp_id, rsp_data, rsp_ovf, e.id, e.d, e.o);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] op1(input int i, input logic [1:0] o);
    return 8'(o) << (2*i);
  endfunction

  function automatic logic [31:0] dat1(input int i, input logic [7:0] d);
    return 32'(d) << (8*i);
  endfunction

  // One cycle: drive at posedge+1, check grant at negedge, queue response.
  task automatic step(input logic [3:0] v, input logic [7:0] op, input logic [31:0] data,
                      input logic [3:0] exp_rdy, input bit push, input int exp_id,
                      input logic [15:0] exp_d, input logic exp_o);
    rsp_t e;
    req_valid = v;
    req_op    = op;
    req_data  = data;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (push) begin
      e.id = exp_id; e.d = exp_d; e.o = exp_o;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic one(input int i, input logic [1:0] o, input logic [7:0] d,
                     input logic [15:0] exp_d, input logic exp_o);
    step(4'(1 << i), op1(i, o), dat1(i, d), 4'(1 << i), 1'b1, i, exp_d, exp_o);
  endtask

  task automatic idle();
    step(4'b0000, 8'h00, 32'h0, 4'b0000, 1'b0, 0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] acc;
    logic        ovf;
    logic [16:0] s;
    int          g;

    // Reset state, with requests presented during reset
    rst_n = 1'b0; req_valid = 4'b0011; req_op = 8'h00; req_data = 32'h0000_0101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("reset_rsp_ovf", 32'(rsp_ovf), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Requester 0 ADD 0x05 back-to-back
    one(0, ADD, 8'h05, 16'h0005, 1'b0);
    one(0, ADD, 8'h05, 16'h000A, 1'b0);
    one(0, ADD, 8'h05, 16'h000F, 1'b0);
    idle();

    // All valid READ: ptr is 1 after the grants to 0, rotation 1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      g = (1 + k) % 4;
      step(4'b1111, {4{READ}}, 32'h0, 4'(1 << g), 1'b1, g,
           (g == 0) ? 16'h000F : 16'h0000, 1'b0);
    end

    // Requester 2: LOAD 0xFF then 257 ADD 0xFF through the wrap
    one(2, LOAD, 8'hFF, 16'h00FF, 1'b0);
    acc = 16'h00FF; ovf = 1'b0;
    for (int n = 0; n < 257; n++) begin
      s   = {1'b0, acc} + 17'h000FF;
      acc = s[15:0];
      ovf = ovf | s[16];
      one(2, ADD, 8'hFF, acc, ovf);
    end
    one(2, READ, 8'h00, 16'h00FE, 1'b1);
    one(2, ADD, 8'h01, 16'h00FF, 1'b1);
    one(2, CLR, 8'h00, 16'h0000, 1'b0);

    // Context isolation (ptr = 3 here)
    one(1, ADD, 8'h10, 16'h0010, 1'b0);
    one(3, ADD, 8'h20, 16'h0020, 1'b0);
    step(4'b1010, {READ, 2'b00, READ, 2'b00}, 32'h0, 4'b0010, 1'b1, 1, 16'h0010, 1'b0);
    step(4'b1000, {READ, 6'b0}, 32'h0, 4'b1000, 1'b1, 3, 16'h0020, 1'b0);
    step(4'b0101, {2'b00, READ, 2'b00, READ}, 32'h0, 4'b0001, 1'b1, 0, 16'h000F, 1'b0);
    step(4'b0100, {4'b0, READ, 2'b0}, 32'h0, 4'b0100, 1'b1, 2, 16'h0000, 1'b0);

    // Only requester 3 valid with ptr = 1, then ptr must be 0
    one(0, READ, 8'h00, 16'h000F, 1'b0);
    one(3, READ, 8'h00, 16'h0020, 1'b0);
    step(4'b1111, {4{READ}}, 32'h0, 4'b0001, 1'b1, 0, 16'h000F, 1'b0);
    step(4'b1110, {4{READ}}, 32'h0, 4'b0010, 1'b1, 1, 16'h0010, 1'b0);
    idle();

    // Reset mid-stream with requesters 0 and 1 valid
    rst_n = 1'b0;
    step(4'b0011, 8'h00, 32'h0000_0101, 4'b0000, 1'b0, 0, 16'h0, 1'b0);
    rst_n = 1'b1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post_reset_rsp_data", 32'(rsp_data), 32'h0);
    chk("post_reset_rsp_id", 32'(rsp_id), 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      step(4'b1111, {4{READ}}, 32'h0, 4'(1 << k), 1'b1, k, 16'h0000, 1'b0);
    idle();
    idle();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
